descrambler: RTL and testbench
==============================

# descrambler

Receive-side inverse of the AUI 257-bit block scrambler. It applies the same additive keystream, polynomial x^58 + x^39 + 1 with an all-ones seed, to each accepted 257-bit transcoded block. The result is the original pre-scrambling block. It sits after block alignment in the RX path and feeds the 256b/257b decoder, with a valid/ready handshake on both sides.

## Interface
- No parameters; width fixed at 257 bits, LFSR fixed at 58 bits.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  257  scrambled block; bit 0 is first on line.
- `in_valid`  in  1  `in_data` holds a block.
- `in_ready`  out  1  block is accepted on `in_valid && in_ready`.
- `seed_load`  in  1  single-cycle pulse that reloads the LFSR seed (realignment/resync).
- `data_out`  out  257  descrambled block.
- `valid`  out  1  `data_out` holds a block.
- `out_ready`  in  1  downstream accepts on `valid && out_ready`.
- `blk_count`  out  32  number of descrambled blocks delivered since reset/seed_load. Present only with `DESCRAMBLER_STATS_EN`.

## Operation
- LFSR state `s[57:0]`; seed is 58'h3FFFFFFFFFFFFFF.
- Per accepted block, serial loop i = 0..256:
  - fb = s[57] ^ s[38]
  - out[i] = in_data[i] ^ fb
  - s = {s[56:0], fb}
- Keystream is data-independent. Block k on RX uses exactly the keystream chunk of block k on TX, provided both sides start from the seed.
- State advances by 257 steps only on an accepted input block. Stalls, idle cycles and backpressure never advance it.
- `seed_load` sets s to the seed.
  - If it coincides with an accepted block, the reload applies first. That block is descrambled from the seed, and s ends at the seed advanced by 257.
  - `seed_load` does not flush the output register.
- Single output register (one-deep pipeline): `in_ready = !valid || out_ready`, combinational.
- Output update on an accepted input: `data_out` is loaded and `valid` is set to 1.
- If the output is consumed with no new input, `valid` is cleared to 0. `data_out` holds its last value.
- Simultaneous consume and accept: the new block replaces the old one in the same cycle, and `valid` stays 1.
- `data_out` must stay stable while `valid && !out_ready`.

## Timing
- Reset values: `data_out` = 0, `valid` = 0, s = seed, `blk_count` = 0. During reset, `in_ready` = 1 and no input is accepted.
- Latency is 1 cycle: a block accepted on edge n appears on `data_out` / `valid` after edge n.
- Throughput is one block per cycle while `out_ready` = 1.
- Reset asserted mid-stream discards the held output and restores the seed on the next edge.
- The 257-step unroll is one combinational stage and must close timing at the AUI block clock.

## Configuration
- `DESCRAMBLER_STATS_EN` defined:
  - The `blk_count` port and its counter exist.
  - The counter increments on each output handshake (`valid && out_ready`).
  - It clears to 0 on reset or `seed_load`. On simultaneous `seed_load` and handshake, it is set to 0 (clear wins).
  - It wraps from 32'hFFFFFFFF to 0.
- Not defined: the port and counter are absent. Datapath behaviour is otherwise identical.

## Test plan
- Reset, then `in_data` = 0 with `in_valid` = 1 and `out_ready` = 1 -> one cycle later, `valid` = 1 and `data_out` bits 0..38 = 0, bit 39 = 1.
- Back-to-back loopback of 1000 random blocks through the TX scrambler into the descrambler, with no stalls -> every `data_out` equals the original block, in order, at 1 block/cycle.
- Same stream with random `in_valid` gaps and random `out_ready` deassertion:
  - no loss or duplication;
  - `data_out` stable while stalled;
  - `in_ready` = 0 only when `valid && !out_ready`.
- Mid-stream `seed_load` coincident with an accepted block, with the scrambler reset to its seed at the same block -> that block and all following blocks match the originals. Also: `blk_count` reads 0 after the pulse and counts from there (stats build).
- Assert `rst` for 1 cycle while `valid` = 1 and stalled -> `valid` = 0 and `data_out` = 0 after the edge. The next zero block reproduces the first-block pattern above.
- Stats build: preload the counter near its limit through a force, then perform 3 handshakes -> `blk_count` goes FFFFFFFE, FFFFFFFF, 0.

Source files
------------

// File: rtl/descrambler.sv
// descrambler: AUI 257-bit additive descrambler (x^58 + x^39 + 1, all-ones seed); define DESCRAMBLER_STATS_EN for blk_count
module descrambler (
  input  logic         clk,
  input  logic         rst,
  input  logic [256:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         seed_load,
  output logic [256:0] data_out,
  output logic         valid,
  input  logic         out_ready
`ifdef DESCRAMBLER_STATS_EN
  ,
  output logic [31:0]  blk_count
`endif
);
  localparam logic [57:0] seed_val = '1;
  logic [57:0]  s;
  logic [57:0]  st;
  logic [256:0] ks;
  logic         accept;
  assign in_ready = rst || !valid || out_ready;
  assign accept   = in_valid && in_ready && !rst;
  // unrolled 257-step keystream starting from the seed when a reload coincides with the block
  always_comb begin
    st = seed_load ? seed_val : s;
    ks = '0;
    for (int i = 0; i < 257; i++) begin
      ks[i] = st[57] ^ st[38];
      st    = {st[56:0], ks[i]};
    end
  end
  // LFSR advances only on accepted blocks; single output register with pass-through on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= seed_val;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      s        <= accept ? st : seed_load ? seed_val : s;
      data_out <= accept ? in_data ^ ks : data_out;
      valid    <= accept || (valid && !out_ready);
    end
  end
`ifdef DESCRAMBLER_STATS_EN
  // delivered-block counter; clear wins over a coincident handshake
  always_ff @(posedge clk) begin
    if (rst || seed_load) blk_count <= '0;
    else if (valid && out_ready) blk_count <= blk_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_descrambler.sv
// tb_descrambler: scoreboard loopback bench for descrambler against a serial TX scrambler model
module tb_descrambler;
  localparam logic [57:0] seed_val = '1;
  logic         clk = 1'b0;
  logic         rst;
  logic [256:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         seed_load;
  logic [256:0] data_out;
  logic         valid;
  logic         out_ready;
`ifdef DESCRAMBLER_STATS_EN
  logic [31:0]  blk_count;
`endif
  logic [256:0] q[$];
  logic [57:0]  tx_s;
  logic [31:0]  cnt_m;
  int           n_cmp = 0;
  int           n_bad = 0;

  descrambler dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .seed_load(seed_load), .data_out(data_out), .valid(valid), .out_ready(out_ready)
`ifdef DESCRAMBLER_STATS_EN
    , .blk_count(blk_count)
`endif
  );

  always #5 clk = ~clk;

  // serial TX scrambler exactly as the algorithm is written: one bit per step
  function automatic logic [256:0] scr(input logic [256:0] d, input logic [57:0] si, output logic [57:0] so);
    logic [256:0] r;
    logic fb;
    so = si;
    for (int i = 0; i < 257; i++) begin
      fb   = so[57] ^ so[38];
      r[i] = d[i] ^ fb;
      so   = {so[56:0], fb};
    end
    return r;
  endfunction

  function automatic logic [256:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one cycle: drive, check handshake-side values before the edge, check register values after it
  task automatic step(input logic v, input logic [256:0] d, input logic o, input logic sl);
    logic [57:0]  ts, ns;
    logic [256:0] sd, held, e;
    logic         acc, hs, stall;
    ts = sl ? seed_val : tx_s;
    sd = scr(d, ts, ns);
    in_valid = v; in_data = sd; out_ready = o; seed_load = sl;
    #1;
    chk("in_ready", {256'b0, in_ready}, {256'b0, !(valid && !o)});
    acc = v && in_ready;
    hs = valid && o;
    stall = valid && !o;
    held = data_out;
    if (hs) begin
      chk("q_nonempty", {256'b0, q.size() != 0}, 257'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("data", data_out, e);
      end
    end
    if (acc) begin
      q.push_back(d);
      tx_s = ns;
    end else if (sl) tx_s = seed_val;
    if (sl) cnt_m = 0;
    else if (hs) cnt_m = cnt_m + 1;
    @(posedge clk); #1;
    in_valid = 1'b0; seed_load = 1'b0;
    if (stall) chk("stable", data_out, held);
    chk("valid", {256'b0, valid}, {256'b0, acc || stall});
`ifdef DESCRAMBLER_STATS_EN
    chk("blk_count", {225'b0, blk_count}, {225'b0, cnt_m});
`endif
  endtask

  initial begin
    logic [57:0]  dummy;
    logic [256:0] ks0;
    ks0 = scr('0, seed_val, dummy);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; seed_load = 1'b0; out_ready = 1'b0;
    tx_s = seed_val; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {256'b0, valid}, 257'd0);
    chk("rst_data", data_out, '0);
    chk("rst_in_ready", {256'b0, in_ready}, 257'd1);
`ifdef DESCRAMBLER_STATS_EN
    chk("rst_blk_count", {225'b0, blk_count}, '0);
`endif
    rst = 1'b0;
    step(1'b1, ks0, 1'b1, 1'b0);
    chk("first_bits", {217'b0, data_out[39:0]}, {217'b0, 40'h80_0000_0000});
    for (int i = 0; i < 1000; i++) step(1'b1, rnd(), 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drained", {225'b0, q.size()}, '0);
    for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b1, 1'b0);
    step(1'b1, rnd(), 1'b1, 1'b1);
`ifdef DESCRAMBLER_STATS_EN
    chk("count_after_seed", {225'b0, blk_count}, '0);
`endif
    for (int i = 0; i < 40; i++) step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drained2", {225'b0, q.size()}, '0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("in_ready_in_rst", {256'b0, in_ready}, 257'd1);
    @(posedge clk); #1;
    chk("mid_rst_valid", {256'b0, valid}, 257'd0);
    chk("mid_rst_data", data_out, '0);
    rst = 1'b0;
    q.delete(); tx_s = seed_val; cnt_m = 0;
    step(1'b1, ks0, 1'b1, 1'b0);
    chk("first_bits_again", {217'b0, data_out[39:0]}, {217'b0, 40'h80_0000_0000});
    chk("first_block_again", data_out, ks0);
`ifdef DESCRAMBLER_STATS_EN
    step(1'b1, rnd(), 1'b0, 1'b0);
    force dut.blk_count = 32'hFFFF_FFFD;
    #1;
    release dut.blk_count;
    cnt_m = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b1, 1'b0);
    chk("wrap", {225'b0, blk_count}, '0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
